// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline boundary: resolves forwarded operands for Rn and Rm/Rd, registers them with the
// immediate choice, control word and destination, and keeps saturating hazard counters for debug.
module id_ex_operand_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        WARrn,
  input  logic [1:0]        WARrm,
  input  logic [DATA_W-1:0] rf_rn_data,
  input  logic [DATA_W-1:0] rf_rm_data,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] shmul_result,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic              use_imm,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [4:0]        rd_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] opa_ex,
  output logic [DATA_W-1:0] opb_ex,
  output logic [DATA_W-1:0] store_data_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic [4:0]        rd_ex,
  output logic              valid_ex,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [4:0] BUBBLE_RD = 5'd31;

  function automatic logic [DATA_W-1:0] selOperand(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rfData,
    input logic [DATA_W-1:0] aluData,
    input logic [DATA_W-1:0] memData,
    input logic [DATA_W-1:0] shmulData
  );
    logic [DATA_W-1:0] result;
    case (sel)
      2'b01:   result = aluData;
      2'b10:   result = memData;
      2'b11:   result = shmulData;
      default: result = rfData;
    endcase
    return result;
  endfunction

  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdM;
  logic [DATA_W-1:0] opbNext;
  logic [CTRL_W-1:0] ctrlNext;
  logic [4:0]        rdNext;
  logic              loadEn;
  logic              anyFwd;

  always_comb begin
    fwdA     = selOperand(WARrn, rf_rn_data, alu_result_ex, mem_result, shmul_result);
    fwdM     = selOperand(WARrm, rf_rm_data, alu_result_ex, mem_result, shmul_result);
    opbNext  = use_imm ? imm_ext : fwdM;
    // An invalid slot is squashed to a no-op so it can never write back.
    ctrlNext = valid_in ? ctrl_in : '0;
    rdNext   = valid_in ? rd_in : BUBBLE_RD;
    loadEn   = !flush && !stall;
    anyFwd   = (WARrn != 2'b00) || (WARrm != 2'b00);
  end

  // Data registers are left untouched by a flush; only the control side is bubbled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_ex        <= '0;
      opb_ex        <= '0;
      store_data_ex <= '0;
    end else if (loadEn) begin
      opa_ex        <= fwdA;
      opb_ex        <= opbNext;
      store_data_ex <= fwdM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_ex  <= '0;
      rd_ex    <= '0;
      valid_ex <= 1'b0;
    end else if (flush) begin
      ctrl_ex  <= '0;
      rd_ex    <= BUBBLE_RD;
      valid_ex <= 1'b0;
    end else if (!stall) begin
      ctrl_ex  <= ctrlNext;
      rd_ex    <= rdNext;
      valid_ex <= valid_in;
    end
  end

  // Counter index: 0 = forwarded loads, 1 = stall cycles, 2 = bubble cycles.
  logic [2:0]       cntInc;
  logic [CNT_W-1:0] cntReg [3];

  always_comb begin
    cntInc[0] = loadEn && valid_in && anyFwd;
    cntInc[1] = !flush && stall;
    cntInc[2] = flush;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cntReg[gi] <= '0;
        end else if (cntInc[gi] && (cntReg[gi] != {CNT_W{1'b1}})) begin
          cntReg[gi] <= cntReg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign fwd_cnt    = cntReg[0];
  assign stall_cnt  = cntReg[1];
  assign bubble_cnt = cntReg[2];

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expected ID/EX state is queued as each cycle is driven
// and popped for comparison one edge later.
module tb_id_ex_operand_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        WARrn = '0, WARrm = '0;
  logic [DATA_W-1:0] rf_rn_data = '0, rf_rm_data = '0, alu_result_ex = '0;
  logic [DATA_W-1:0] mem_result = '0, shmul_result = '0, imm_ext = '0;
  logic              use_imm = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [4:0]        rd_in = '0;
  logic              valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] opa_ex, opb_ex, store_data_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [4:0]        rd_ex;
  logic              valid_ex;
  logic [CNT_W-1:0]  fwd_cnt, stall_cnt, bubble_cnt;

  id_ex_operand_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .WARrn(WARrn), .WARrm(WARrm),
    .rf_rn_data(rf_rn_data), .rf_rm_data(rf_rm_data), .alu_result_ex(alu_result_ex),
    .mem_result(mem_result), .shmul_result(shmul_result), .imm_ext(imm_ext),
    .use_imm(use_imm), .ctrl_in(ctrl_in), .rd_in(rd_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .opa_ex(opa_ex), .opb_ex(opb_ex),
    .store_data_ex(store_data_ex), .ctrl_ex(ctrl_ex), .rd_ex(rd_ex), .valid_ex(valid_ex),
    .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] sd;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              valid;
    logic [CNT_W-1:0]  fc;
    logic [CNT_W-1:0]  sc;
    logic [CNT_W-1:0]  bc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '0;
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
    logic [DATA_W-1:0] src [4];
    src[0] = rf; src[1] = alu_result_ex; src[2] = mem_result; src[3] = shmul_result;
    return src[sel];
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".opa"},   opa_ex, e.opa);
    check({tag, ".opb"},   opb_ex, e.opb);
    check({tag, ".sd"},    store_data_ex, e.sd);
    check({tag, ".ctrl"},  64'(ctrl_ex), 64'(e.ctrl));
    check({tag, ".rd"},    64'(rd_ex), 64'(e.rd));
    check({tag, ".valid"}, 64'(valid_ex), 64'(e.valid));
    check({tag, ".fcnt"},  64'(fwd_cnt), 64'(e.fc));
    check({tag, ".scnt"},  64'(stall_cnt), 64'(e.sc));
    check({tag, ".bcnt"},  64'(bubble_cnt), 64'(e.bc));
  endtask

  // Predict the post-edge state from the current inputs, clock once, compare.
  task automatic step(input string tag);
    exp_t e;
    logic [DATA_W-1:0] fm;
    e = cur;
    if (flush) begin
      e.valid = 1'b0; e.ctrl = '0; e.rd = 5'd31; e.bc = sat_inc(e.bc);
    end else if (stall) begin
      e.sc = sat_inc(e.sc);
    end else begin
      fm      = pick(WARrm, rf_rm_data);
      e.opa   = pick(WARrn, rf_rn_data);
      e.opb   = use_imm ? imm_ext : fm;
      e.sd    = fm;
      e.valid = valid_in;
      e.ctrl  = valid_in ? ctrl_in : '0;
      e.rd    = valid_in ? rd_in : 5'd31;
      if (valid_in && (WARrn != 2'b00 || WARrm != 2'b00)) e.fc = sat_inc(e.fc);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    txn++;
    $display("txn %0d %s: flush=%0b stall=%0b opa=%0h opb=%0h sd=%0h rd=%0d valid=%0b cnt=%0d/%0d/%0d",
             txn, tag, flush, stall, opa_ex, opb_ex, store_data_ex, rd_ex, valid_ex,
             fwd_cnt, stall_cnt, bubble_cnt);
    check_all(tag, e);
    cur = e;
  endtask

  logic [CNT_W-1:0] sc_before;

  initial begin
    // Reset asserted while stalling, checked before any clock edge.
    stall = 1'b1;
    #1 reset = 1'b1;
    #2;
    check_all("reset", '0);
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0;
    cur = '0;

    // Select sweep: both paths forward the same source.
    rf_rn_data = 64'd1; rf_rm_data = 64'd1; alu_result_ex = 64'd2;
    mem_result = 64'd3; shmul_result = 64'd4;
    valid_in = 1'b1; ctrl_in = 16'h00A5; rd_in = 5'd7;
    for (int s = 0; s < 4; s++) begin
      WARrn = 2'(s); WARrm = 2'(s);
      step("sweep");
      check("sweep.opa_val", opa_ex, 64'(s + 1));
      check("sweep.opb_val", opb_ex, 64'(s + 1));
      check("sweep.sd_val", store_data_ex, 64'(s + 1));
    end
    check("sweep.fwd_cnt", 64'(fwd_cnt), 64'd3);

    // STUR with immediate: opb takes imm, store data still forwarded.
    use_imm = 1'b1; imm_ext = 64'h10; WARrn = 2'b00; WARrm = 2'b10;
    mem_result = 64'hABCD; rf_rn_data = 64'h55;
    step("stur");
    check("stur.opb", opb_ex, 64'h10);
    check("stur.sd", store_data_ex, 64'hABCD);
    use_imm = 1'b0;

    // Stall hold: load A then three stalled cycles with changing inputs.
    WARrn = 2'b01; WARrm = 2'b11; alu_result_ex = 64'hA1; shmul_result = 64'hA2;
    ctrl_in = 16'h1234; rd_in = 5'd3;
    step("loadA");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_result_ex = 64'hB0 + 64'(i); shmul_result = 64'hC0 + 64'(i);
      ctrl_in = 16'h4321 + 16'(i); rd_in = 5'd10 + 5'(i);
      step("stall");
      check("stall.opa_hold", opa_ex, 64'hA1);
    end
    check("stall.cnt3", 64'(stall_cnt), 64'd3);
    stall = 1'b0;
    step("loadB");
    check("loadB.opa", opa_ex, 64'hB2);
    check("loadB.sd", store_data_ex, 64'hC2);

    // Flush beats stall.
    sc_before = stall_cnt;
    stall = 1'b1; flush = 1'b1; valid_in = 1'b1; ctrl_in = 16'hFFFF; rd_in = 5'd5;
    step("flush");
    check("flush.valid", 64'(valid_ex), 64'd0);
    check("flush.rd", 64'(rd_ex), 64'd31);
    check("flush.scnt", 64'(stall_cnt), 64'(sc_before));
    check("flush.bcnt", 64'(bubble_cnt), 64'd1);
    stall = 1'b0; flush = 1'b0;

    // Invalid slot with forwarding: squashed, not counted.
    valid_in = 1'b0; WARrn = 2'b10; ctrl_in = 16'h0F0F; rd_in = 5'd9;
    step("invalid");
    check("invalid.rd", 64'(rd_ex), 64'd31);
    valid_in = 1'b1;

    // Reset mid-stall clears immediately; first edge after release stalls.
    stall = 1'b1;
    reset = 1'b1;
    #1;
    check_all("midreset", '0);
    cur = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Saturation: 20 stalled cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++) step("sat");
    check("sat.cnt", 64'(stall_cnt), 64'd15);
    step("sat_hold");
    check("sat.hold", 64'(stall_cnt), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline boundary, directly downstream of forwarding_unit.
- Consumes WARrn/WARrm select codes and picks each operand from the register file or a forwarding source.
- Registers operands, immediate choice, control word and destination into the ID/EX register, with stall (hold) and flush (bubble).
- Keeps saturating hazard counters readable by the debug path.

Parameters:
DATA_W, 64, operand/datapath width
CTRL_W, 16, width of opaque decoded control bundle
CNT_W, 16, width of each hazard counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
WARrn  input  2  Rn operand select from forwarding unit
WARrm  input  2  Rm/Rd (store data, CBZ) operand select from forwarding unit
rf_rn_data  input  DATA_W  register file read port for Rn
rf_rm_data  input  DATA_W  register file read port for Rm/Rd
alu_result_ex  input  DATA_W  current EX-stage ALU result (select 01)
mem_result  input  DATA_W  MEM-stage result (select 10)
shmul_result  input  DATA_W  EX-stage shifter/multiplier result (select 11)
imm_ext  input  DATA_W  sign/zero-extended immediate from decode
use_imm  input  1  1: operand B is the immediate
ctrl_in  input  CTRL_W  decoded control bundle
rd_in  input  5  destination register index
valid_in  input  1  decode slot holds a real instruction
stall  input  1  hold ID/EX contents this cycle
flush  input  1  insert bubble into ID/EX this cycle
opa_ex  output  DATA_W  registered operand A (forwarded Rn)
opb_ex  output  DATA_W  registered operand B (immediate or forwarded Rm)
store_data_ex  output  DATA_W  registered forwarded Rm/Rd value (STUR data, CBZ test)
ctrl_ex  output  CTRL_W  registered control bundle
rd_ex  output  5  registered destination
valid_ex  output  1  registered valid
fwd_cnt  output  CNT_W  instructions loaded with at least one nonzero select
stall_cnt  output  CNT_W  cycles with stall applied
bubble_cnt  output  CNT_W  cycles with flush applied

Behaviour:
- Select decode is combinational, identical for both paths. 00 picks the rf read data, 01 alu_result_ex, 10 mem_result, 11 shmul_result.
- fwd_a is the selected Rn value. fwd_m is the selected Rm value.
- opb_next = use_imm ? imm_ext : fwd_m. store_data_next = fwd_m, regardless of use_imm.
- Latency: one cycle from decode inputs to *_ex outputs. No combinational input-to-output path.
- Reset (async, immediate): all data, ctrl and rd outputs are 0, valid_ex=0, all counters 0.
- Per-edge priority: flush > stall > load.
  - flush=1: valid_ex<=0, ctrl_ex<=0, rd_ex<=5'd31. Data outputs keep their values (don't-care). bubble_cnt increments.
  - flush=0, stall=1: all ID/EX registers hold. stall_cnt increments.
  - flush=0, stall=0 (load): registers take the next values, valid_ex<=valid_in.
- Counter updates:
  - Load with valid_in=0: ctrl_ex<=0 and rd_ex<=31, so an invalid slot never writes back.
  - Load with valid_in=1 and (WARrn!=0 or WARrm!=0): fwd_cnt increments.
- Simultaneous flush and stall: flush wins. A bubble is inserted and only bubble_cnt increments.
- Counters saturate at all-ones. They never wrap and are cleared only by reset.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. First edge after deassertion behaves per priority above.
- rd_ex=31 (XZR) is the bubble destination. The downstream forwarding logic already ignores register 31.

Test Plan:
- Reset: assert reset with stall=1 → all outputs 0, valid_ex=0, counters 0 without any clock edge.
- Select sweep: rf_rn_data=1, alu_result_ex=2, mem_result=3, shmul_result=4, use_imm=0, WARrn=WARrm over 00/01/10/11, valid_in=1 → next cycle opa_ex=opb_ex=store_data_ex = 1/2/3/4. fwd_cnt ends at 3.
- STUR with immediate: use_imm=1, imm_ext=0x10, WARrm=10, mem_result=0xABCD → opb_ex=0x10, store_data_ex=0xABCD.
- Stall hold: load A, then stall=1 for 3 cycles while inputs change → *_ex stay at A values, stall_cnt=3. Release → new values one cycle later.
- Flush priority: stall=1 and flush=1 together, valid_in=1 → valid_ex=0, ctrl_ex=0, rd_ex=31, bubble_cnt+1, stall_cnt unchanged.
- Saturation: CNT_W=4, stall held 20 cycles → stall_cnt=15 and stays 15.
